// File: rtl/dataflow_pkg.sv
// Shared dataflow types: loop-carry FSM states used by dataflow_carry.
package dataflow_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_LOOP = 1'b1
  } carry_state_t;

endpackage

// File: rtl/dataflow_out_reg.sv
// One-entry output buffer (valid/ready both sides); full throughput when drained each cycle.
module dataflow_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             buf_valid_r;
  logic [WIDTH-1:0] buf_data_r;

  assign in_ready  = !buf_valid_r | out_ready;
  assign out_valid = buf_valid_r;
  assign out_data  = buf_data_r;

  // Capture on accept, otherwise empty the entry once downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_r <= 1'b0;
      buf_data_r  <= {WIDTH{1'b0}};
    end else if (in_valid && in_ready) begin
      buf_valid_r <= 1'b1;
      buf_data_r  <= in_data;
    end else if (out_ready) begin
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

endmodule

// File: rtl/dataflow_carry.sv
// Loop-carried variable merge: init value first, then back-edge values while cond=1.
// Optional output register enabled by macro DATAFLOW_CARRY_OUT_REG_EN.
module dataflow_carry
  import dataflow_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_valid,
  output logic             init_ready,
  input  logic [WIDTH-1:0] init_data,
  input  logic             cond_valid,
  output logic             cond_ready,
  input  logic             cond_data,
  input  logic             loop_valid,
  output logic             loop_ready,
  input  logic [WIDTH-1:0] loop_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  carry_state_t     state_r;
  logic             dn_ready_s;
  logic             vld_s;
  logic [WIDTH-1:0] dat_s;
  logic             init_ready_s;
  logic             cond_ready_s;
  logic             loop_ready_s;

  // Steer the active source to the output stage according to FSM state
  always_comb begin
    vld_s        = 1'b0;
    dat_s        = {WIDTH{1'b0}};
    init_ready_s = 1'b0;
    cond_ready_s = 1'b0;
    loop_ready_s = 1'b0;
    case (state_r)
      S_INIT: begin
        vld_s        = init_valid;
        dat_s        = init_data;
        init_ready_s = dn_ready_s;
      end
      S_LOOP: begin
        if (cond_valid && cond_data) begin
          vld_s        = loop_valid;
          dat_s        = loop_data;
          loop_ready_s = dn_ready_s;
          cond_ready_s = loop_valid & dn_ready_s;
        end else if (cond_valid) begin
          // Exit token is consumed without producing an output
          cond_ready_s = 1'b1;
        end else begin
          vld_s = 1'b0;
        end
      end
      default: begin
        vld_s = 1'b0;
      end
    endcase
  end

  assign init_ready = init_ready_s & rst_n;
  assign cond_ready = cond_ready_s & rst_n;
  assign loop_ready = loop_ready_s & rst_n;

  // Enter the loop on an init transfer, leave it on a cond=0 transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_INIT;
    end else begin
      case (state_r)
        S_INIT: begin
          if (init_valid && init_ready) begin
            state_r <= S_LOOP;
          end else begin
            state_r <= S_INIT;
          end
        end
        S_LOOP: begin
          if (cond_valid && cond_ready && !cond_data) begin
            state_r <= S_INIT;
          end else begin
            state_r <= S_LOOP;
          end
        end
        default: begin
          state_r <= S_INIT;
        end
      endcase
    end
  end

`ifdef DATAFLOW_CARRY_OUT_REG_EN
  logic stage_ready_s;

  dataflow_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (vld_s & rst_n),
    .in_ready (stage_ready_s),
    .in_data  (dat_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  assign dn_ready_s = stage_ready_s;
`else
  assign dn_ready_s = out_ready;
  assign out_valid  = vld_s & rst_n;
  assign out_data   = rst_n ? dat_s : {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_dataflow_carry.sv
// Self-checking bench for dataflow_carry: directed loop scenarios plus randomized loop programs.
module tb_dataflow_carry;

  localparam int W = 32;
`ifdef DATAFLOW_CARRY_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init_valid = 1'b0;
  logic         init_ready;
  logic [W-1:0] init_data = '0;
  logic         cond_valid = 1'b0;
  logic         cond_ready;
  logic         cond_data = 1'b0;
  logic         loop_valid = 1'b0;
  logic         loop_ready;
  logic [W-1:0] loop_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] init_q[$];
  logic [W-1:0] loop_q[$];
  bit           cond_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] out_log[$];
  int           out_cyc[$];
  int           init_cyc[$];

  dataflow_carry #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_valid(init_valid),
    .init_ready(init_ready),
    .init_data (init_data),
    .cond_valid(cond_valid),
    .cond_ready(cond_ready),
    .cond_data (cond_data),
    .loop_valid(loop_valid),
    .loop_ready(loop_ready),
    .loop_data (loop_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    init_q.delete(); loop_q.delete(); cond_q.delete(); exp_q.delete();
    out_log.delete(); out_cyc.delete(); init_cyc.delete();
  endtask

  task automatic idle_inputs();
    init_valid = 1'b0; cond_valid = 1'b0; loop_valid = 1'b0;
  endtask

  // Token-level driver: presents queued tokens, logs every handshake, drains afterwards.
  task automatic drive(input bit rnd, input int budget);
    int n = 0;
    int drain = 0;
    while (n < budget && (init_q.size() != 0 || cond_q.size() != 0 || loop_q.size() != 0 || drain < 3)) begin
      if (init_q.size() == 0 && cond_q.size() == 0 && loop_q.size() == 0) drain++;
      init_valid = (init_q.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
      init_data  = (init_q.size() != 0) ? init_q[0] : '0;
      cond_valid = (cond_q.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
      cond_data  = (cond_q.size() != 0) ? cond_q[0] : 1'b0;
      loop_valid = (loop_q.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
      loop_data  = (loop_q.size() != 0) ? loop_q[0] : '0;
      out_ready  = (drain != 0) || !rnd || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (init_valid && init_ready) begin void'(init_q.pop_front()); init_cyc.push_back(n); end
      if (cond_valid && cond_ready) void'(cond_q.pop_front());
      if (loop_valid && loop_ready) void'(loop_q.pop_front());
      if (out_valid && out_ready) begin out_log.push_back(out_data); out_cyc.push_back(n); end
      @(posedge clk); #1;
      n++;
    end
    idle_inputs();
    tests_run++;
    if (init_q.size() + cond_q.size() + loop_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drive_timeout: %0d tokens left, expected 0", init_q.size() + cond_q.size() + loop_q.size());
    end
  endtask

  task automatic test_reset();
    init_valid = 1'b1; init_data = 32'd11;
    cond_valid = 1'b1; cond_data = 1'b1;
    loop_valid = 1'b1; loop_data = 32'd12;
    out_ready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
        tests_failed++;
        $display("FAIL reset_out: got valid=%b data=%0d, expected 0/0", out_valid, out_data);
      end
      tests_run++;
      if ({init_ready, cond_ready, loop_ready} !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_ready: got %b, expected 000", {init_ready, cond_ready, loop_ready});
      end
    end
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_loop();
    clear_logs();
    init_q.push_back(32'd5);
    cond_q.push_back(1'b1); cond_q.push_back(1'b1); cond_q.push_back(1'b0);
    loop_q.push_back(32'd6); loop_q.push_back(32'd7);
    exp_q.push_back(32'd5); exp_q.push_back(32'd6); exp_q.push_back(32'd7);
    drive(1'b0, 50);
    tests_run++;
    if (out_log.size() != 3) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d outputs, expected 3", out_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (out_log[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL basic_data[%0d]: got %0d, expected %0d", i, out_log[i], exp_q[i]);
        end
      end
      tests_run++;
      if (out_cyc[1] - out_cyc[0] != 1 || out_cyc[2] - out_cyc[1] != 1) begin
        tests_failed++;
        $display("FAIL basic_b2b: got cycles %0d,%0d,%0d, expected consecutive", out_cyc[0], out_cyc[1], out_cyc[2]);
      end
      tests_run++;
      if (init_cyc.size() != 1 || out_cyc[0] - init_cyc[0] != LAT) begin
        tests_failed++;
        $display("FAIL basic_latency: got out cycle %0d, expected init cycle + %0d", out_cyc[0], LAT);
      end
    end
    // Back in S_INIT: pending cond/loop tokens must not produce a 4th output
    cond_valid = 1'b1; cond_data = 1'b1; loop_valid = 1'b1; loop_data = 32'd99; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || loop_ready !== 1'b0 || cond_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_no_4th: got out_valid=%b loop_ready=%b cond_ready=%b, expected 0/0/0", out_valid, loop_ready, cond_ready);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    clear_logs();
    init_q.push_back(32'd42); cond_q.push_back(1'b0);
    drive(1'b0, 50);
    tests_run++;
    if (out_log.size() != 1 || out_log[0] !== 32'd42) begin
      tests_failed++;
      $display("FAIL basic_new_init: got %0d outputs (first %0d), expected one output 42", out_log.size(), out_log.size() != 0 ? out_log[0] : 0);
    end
  endtask

  task automatic test_exit_no_output();
    clear_logs();
    init_q.push_back(32'd9);
    drive(1'b0, 50);
    tests_run++;
    if (out_log.size() != 1 || out_log[0] !== 32'd9) begin
      tests_failed++;
      $display("FAIL exit_init: got %0d outputs, expected single 9", out_log.size());
    end
    cond_valid = 1'b1; cond_data = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cond_ready !== 1'b1 || out_valid !== 1'b0 || loop_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL exit_cond0: got cond_ready=%b out_valid=%b loop_ready=%b, expected 1/0/0", cond_ready, out_valid, loop_ready);
    end
    @(posedge clk); #1;
    cond_valid = 1'b0; loop_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (init_ready !== 1'b1 || loop_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL exit_state: got init_ready=%b loop_ready=%b, expected 1/0", init_ready, loop_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_early_loop();
    loop_valid = 1'b1; loop_data = 32'd3; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (loop_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL early_loop_ready: got %b, expected 0", loop_ready);
      end
      @(posedge clk); #1;
    end
    clear_logs();
    init_q.push_back(32'd1);
    cond_q.push_back(1'b1); cond_q.push_back(1'b0);
    loop_q.push_back(32'd3);
    drive(1'b0, 50);
    tests_run++;
    if (out_log.size() != 2 || out_log[0] !== 32'd1 || out_log[1] !== 32'd3) begin
      tests_failed++;
      $display("FAIL early_seq: got %0d outputs, expected exactly 1,3", out_log.size());
    end
  endtask

  task automatic test_backpressure();
    int cx = 0;
    int lx = 0;
    int ox = 0;
    logic [W-1:0] od = '0;
    clear_logs();
    init_q.push_back(32'd0);
    drive(1'b0, 50);
    cond_valid = 1'b1; cond_data = 1'b1; loop_valid = 1'b1; loop_data = 32'd8; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cond_valid && cond_ready) cx++;
      if (loop_valid && loop_ready) lx++;
      if (i >= LAT) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'd8) begin
          tests_failed++;
          $display("FAIL bp_hold[%0d]: got valid=%b data=%0d, expected 1/8", i, out_valid, out_data);
        end
      end
      @(posedge clk); #1;
      if (lx != 0) begin cond_valid = 1'b0; loop_valid = 1'b0; end
    end
    tests_run++;
    if (cx != LAT || lx != LAT) begin
      tests_failed++;
      $display("FAIL bp_stall: got cond=%0d loop=%0d transfers, expected %0d", cx, lx, LAT);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cond_valid && cond_ready) cx++;
      if (loop_valid && loop_ready) lx++;
      if (out_valid && out_ready) begin ox++; od = out_data; end
      @(posedge clk); #1;
      if (lx != 0) begin cond_valid = 1'b0; loop_valid = 1'b0; end
    end
    tests_run++;
    if (cx != 1 || lx != 1 || ox != 1 || od !== 32'd8) begin
      tests_failed++;
      $display("FAIL bp_release: got cond=%0d loop=%0d out=%0d data=%0d, expected 1/1/1/8", cx, lx, ox, od);
    end
    cond_valid = 1'b1; cond_data = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cond_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_exit: got cond_ready=%b, expected 1", cond_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_mid_loop();
    clear_logs();
    init_q.push_back(32'd5); cond_q.push_back(1'b1); loop_q.push_back(32'd6);
    drive(1'b0, 50);
    tests_run++;
    if (out_log.size() != 2 || out_log[0] !== 32'd5 || out_log[1] !== 32'd6) begin
      tests_failed++;
      $display("FAIL rst_pre: got %0d outputs, expected 5,6", out_log.size());
    end
    cond_valid = 1'b1; cond_data = 1'b1; loop_valid = 1'b1; loop_data = 32'd77;
    init_valid = 1'b1; init_data = 32'd33; out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || {init_ready, cond_ready, loop_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_mid: got out_valid=%b data=%0d readies=%b, expected 0/0/000", out_valid, out_data, {init_ready, cond_ready, loop_ready});
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    cond_valid = 1'b1; loop_valid = 1'b1;
    @(negedge clk);
    tests_run++;
    if (loop_ready !== 1'b0 || init_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_state: got loop_ready=%b init_ready=%b, expected 0/1", loop_ready, init_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    clear_logs();
    init_q.push_back(32'd20); cond_q.push_back(1'b0);
    drive(1'b0, 50);
    tests_run++;
    if (out_log.size() != 1 || out_log[0] !== 32'd20) begin
      tests_failed++;
      $display("FAIL rst_post: got %0d outputs (first %0d), expected one output 20", out_log.size(), out_log.size() != 0 ? out_log[0] : 0);
    end
  endtask

  task automatic test_random();
    int k;
    logic [W-1:0] v;
    clear_logs();
    // Reference: each program emits its init value, then one value per cond=1 iteration.
    for (int p = 0; p < 20; p++) begin
      v = $urandom;
      init_q.push_back(v); exp_q.push_back(v);
      k = $urandom_range(0, 4);
      for (int j = 0; j < k; j++) begin
        v = $urandom;
        cond_q.push_back(1'b1); loop_q.push_back(v); exp_q.push_back(v);
      end
      cond_q.push_back(1'b0);
    end
    drive(1'b1, 3000);
    tests_run++;
    if (out_log.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d outputs, expected %0d", out_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (out_log[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL rand_data[%0d]: got %0h, expected %0h", i, out_log[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_loop();
    test_exit_no_output();
    test_early_loop();
    test_backpressure();
    test_reset_mid_loop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
